c7bbiu_rd_arb_rr: RTL and testbench

Parametrised N-requester AXI read-address arbiter for the c7bbiu BIU. It is the successor to the fixed two-port IFU/LSU read arbiter.
- Grants by round-robin or fixed priority.
- Holds the AR beat in an output register until the AXI slave accepts it.
- Per-requester outstanding-read counters stop any one requester from overrunning its R-channel tracking.
- Sits between the IFU/LSU/(future DMA) read request ports and the AXI master AR channel, and snoops the R channel for completions.

---
 rtl/c7bbiu_rd_arb_rr_pkg.sv | 20 ++
 rtl/c7bbiu_rr_pick.sv | 55 +++++
 rtl/c7bbiu_rd_arb_rr.sv | 148 ++++++++++++++
 tb/tb_c7bbiu_rd_arb_rr.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c7bbiu_rd_arb_rr_pkg.sv
// Shared AXI encodings and sizing helpers for the c7bbiu read-address arbiter
// and its round-robin picker.
package c7bbiu_rd_arb_rr_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [2:0] AXI_SIZE_WORD   = 3'b010;

    // Legacy fixed-port IDs; in the N-way arbiter these become ID_BASE+index.
    localparam int AXI_RID_IFU = 0;
    localparam int AXI_RID_LSU = 1;

    localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0000;
    localparam logic [2:0] AXI_PROT_DEFAULT  = 3'b000;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/c7bbiu_rr_pick.sv
// Combinational N-way picker: round-robin from a start pointer, or fixed
// priority with the highest eligible index winning.
module c7bbiu_rr_pick
    import c7bbiu_rd_arb_rr_pkg::*;
#(
    parameter int N         = 2,
    parameter int PRIO_MODE = 0,
    parameter int IDX_W     = idx_w(N)
) (
    input  logic [N-1:0]     elig,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IDX_W:0] sum;
    logic           found;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        dbl   = {elig, elig} >> ptr;
        rot   = dbl[N-1:0];
        if (PRIO_MODE == 1) begin
            for (int i = 0; i < N; i++) begin
                if (elig[i]) begin
                    idx = IDX_W'(i);
                end
            end
        end else begin
            // rot[k] is requester (ptr+k) mod N; the first set bit wins.
            for (int k = 0; k < N; k++) begin
                if (!found && rot[k]) begin
                    found = 1'b1;
                    sum   = {1'b0, ptr} + (IDX_W+1)'(k);
                    if (sum >= (IDX_W+1)'(N)) begin
                        sum = sum - (IDX_W+1)'(N);
                    end
                    idx = sum[IDX_W-1:0];
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = (|elig) && (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/c7bbiu_rd_arb_rr.sv
// N-requester AXI read-address arbiter: picks a requester, holds the AR beat
// until accepted, and caps each requester's outstanding reads via R snooping.
module c7bbiu_rd_arb_rr
    import c7bbiu_rd_arb_rr_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int ID_W      = 4,
    parameter int ID_BASE   = 0,
    parameter int MAX_OUTST = 4,
    parameter int PRIO_MODE = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*32-1:0]  req_addr,
    input  logic [N_REQ*8-1:0]   req_len,
    input  logic [N_REQ*3-1:0]   req_size,
    output logic [N_REQ-1:0]     ack,
    output logic [N_REQ-1:0]     outst_full,
    output logic                 ar_valid,
    input  logic                 ar_ready,
    output logic [ID_W-1:0]      ar_id,
    output logic [31:0]          ar_addr,
    output logic [7:0]           ar_len,
    output logic [2:0]           ar_size,
    output logic [1:0]           ar_burst,
    output logic                 ar_lock,
    output logic [3:0]           ar_cache,
    output logic [2:0]           ar_prot,
    input  logic                 r_valid,
    input  logic                 r_ready,
    input  logic [ID_W-1:0]      r_id,
    input  logic                 r_last
);

    localparam int IDX_W = idx_w(N_REQ);
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    logic [N_REQ-1:0] elig, grant, inc_v, dec_v;
    logic [IDX_W-1:0] grant_idx, ptr_q, ptr_d;
    logic             load, r_done;
    logic [CNT_W-1:0] cnt_q [N_REQ];
    logic [CNT_W-1:0] cnt_d [N_REQ];

    logic             ar_valid_q, ar_valid_d;
    logic [ID_W-1:0]  ar_id_q, ar_id_d;
    logic [31:0]      ar_addr_q, ar_addr_d;
    logic [7:0]       ar_len_q, ar_len_d;
    logic [2:0]       ar_size_q, ar_size_d;
    logic [1:0]       ar_burst_q, ar_burst_d;

    c7bbiu_rr_pick #(.N(N_REQ), .PRIO_MODE(PRIO_MODE), .IDX_W(IDX_W)) u_pick (
        .elig  (elig),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (grant_idx)
    );

    // AR handshake: a beat transfers on ar_valid & ar_ready; ar_valid never
    // drops and the fields never change until that transfer happens. A new
    // beat loads when the register is empty or is being emptied this cycle.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            outst_full[i] = (cnt_q[i] == CNT_W'(MAX_OUTST));
        end
        elig = req & ~outst_full;
        load = (|elig) && (!ar_valid_q || ar_ready) && !reset;
        ack  = load ? grant : '0;
    end

    always_comb begin
        ptr_d      = ptr_q;
        ar_valid_d = ar_valid_q && !ar_ready;
        ar_id_d    = ar_id_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_size_d  = ar_size_q;
        ar_burst_d = ar_burst_q;
        if (load) begin
            ptr_d      = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            ar_valid_d = 1'b1;
            ar_id_d    = ID_W'(ID_BASE + int'(grant_idx));
            ar_burst_d = AXI_BURST_INCR;
            ar_addr_d  = '0;
            ar_len_d   = '0;
            ar_size_d  = '0;
            for (int i = 0; i < N_REQ; i++) begin
                if (grant[i]) begin
                    ar_addr_d = req_addr[i*32 +: 32];
                    ar_len_d  = req_len[i*8 +: 8];
                    ar_size_d = req_size[i*3 +: 3];
                end
            end
        end
    end

    // Same-cycle issue and completion cancel; a stray completion at zero is held at zero.
    always_comb begin
        r_done = r_valid && r_ready && r_last;
        for (int i = 0; i < N_REQ; i++) begin
            inc_v[i] = ack[i];
            dec_v[i] = r_done && (r_id == ID_W'(ID_BASE + i));
            cnt_d[i] = cnt_q[i];
            if (inc_v[i] && !dec_v[i]) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (dec_v[i] && !inc_v[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q      <= '0;
            ar_valid_q <= 1'b0;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            ar_valid_q <= ar_valid_d;
            ar_id_q    <= ar_id_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            ar_burst_q <= ar_burst_d;
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign ar_valid = ar_valid_q;
    assign ar_id    = ar_id_q;
    assign ar_addr  = ar_addr_q;
    assign ar_len   = ar_len_q;
    assign ar_size  = ar_size_q;
    assign ar_burst = ar_burst_q;
    assign ar_lock  = 1'b0;
    assign ar_cache = AXI_CACHE_DEFAULT;
    assign ar_prot  = AXI_PROT_DEFAULT;

endmodule

// File: tb/tb_c7bbiu_rd_arb_rr.sv
// Bench for c7bbiu_rd_arb_rr: a 3-requester round-robin instance checked by a
// reference model and AR scoreboard, plus a 2-requester fixed-priority instance.
module tb_c7bbiu_rd_arb_rr;

    localparam int N     = 3;
    localparam int BASE  = 4;
    localparam int MAXO  = 2;
    localparam int BW    = 57;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT (round-robin) ----------------
    logic          reset;
    logic [N-1:0]  req, rereq, ack, outst_full;
    logic [31:0]   addr [N];
    logic [7:0]    len  [N];
    logic [2:0]    size [N];
    logic [N*32-1:0] req_addr_v;
    logic [N*8-1:0]  req_len_v;
    logic [N*3-1:0]  req_size_v;
    logic          ar_valid, ar_ready, ar_lock, r_valid, r_ready, r_last;
    logic [3:0]    ar_id, ar_cache, r_id;
    logic [31:0]   ar_addr;
    logic [7:0]    ar_len;
    logic [2:0]    ar_size, ar_prot;
    logic [1:0]    ar_burst;
    logic [BW-1:0] cur_beat;

    for (genvar g = 0; g < N; g++) begin : g_flat
        assign req_addr_v[g*32 +: 32] = addr[g];
        assign req_len_v[g*8 +: 8]    = len[g];
        assign req_size_v[g*3 +: 3]   = size[g];
    end
    assign cur_beat = {ar_prot, ar_cache, ar_lock, ar_burst, ar_size, ar_len, ar_addr, ar_id};

    c7bbiu_rd_arb_rr #(.N_REQ(N), .ID_W(4), .ID_BASE(BASE), .MAX_OUTST(MAXO), .PRIO_MODE(0)) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr_v), .req_len(req_len_v),
        .req_size(req_size_v), .ack(ack), .outst_full(outst_full), .ar_valid(ar_valid),
        .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len),
        .ar_size(ar_size), .ar_burst(ar_burst), .ar_lock(ar_lock), .ar_cache(ar_cache),
        .ar_prot(ar_prot), .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_last(r_last)
    );

    // ---------------- second DUT (fixed priority) ----------------
    logic          rst2, ar_valid2, ar_lock2;
    logic [1:0]    req2, ack2, full2, ar_burst2;
    logic [63:0]   addr2_v;
    logic [3:0]    ar_id2, ar_cache2;
    logic [31:0]   ar_addr2;
    logic [7:0]    ar_len2;
    logic [2:0]    ar_size2, ar_prot2;

    c7bbiu_rd_arb_rr #(.N_REQ(2), .ID_W(4), .ID_BASE(2), .MAX_OUTST(4), .PRIO_MODE(1)) dut2 (
        .clk(clk), .reset(rst2), .req(req2), .req_addr(addr2_v), .req_len(16'h0000),
        .req_size(6'b010_010), .ack(ack2), .outst_full(full2), .ar_valid(ar_valid2),
        .ar_ready(1'b1), .ar_id(ar_id2), .ar_addr(ar_addr2), .ar_len(ar_len2),
        .ar_size(ar_size2), .ar_burst(ar_burst2), .ar_lock(ar_lock2), .ar_cache(ar_cache2),
        .ar_prot(ar_prot2), .r_valid(1'b0), .r_ready(1'b0), .r_id(4'h0), .r_last(1'b0)
    );

    // ---------------- scoreboard / model state ----------------
    int            total = 0;
    int            bad   = 0;
    logic [BW-1:0] exp_q [$];
    int            m_cnt [N];
    int            m_ptr;
    logic          m_valid;
    logic [N-1:0]  last_ack;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_r();
        r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0; r_id = 4'h0;
    endtask

    task automatic new_req_fields(input int i);
        addr[i] = $urandom;
        len[i]  = 8'($urandom_range(0, 15));
        size[i] = 3'($urandom_range(0, 3));
    endtask

    // One clock cycle: inputs are already driven (at the negedge); check the
    // DUT against the model, advance the model at the edge, then react.
    task automatic step();
        logic [N-1:0] m_full, m_elig, m_ack;
        logic         m_load, dec;
        int           gi, g;
        #1;
        gi = 0;
        for (int i = 0; i < N; i++) m_full[i] = (m_cnt[i] == MAXO);
        m_elig = req & ~m_full;
        chk("outst_full", 64'(outst_full), 64'(m_full));
        chk("ar_valid", 64'(ar_valid), 64'(m_valid));
        if (m_valid) begin
            if (exp_q.size() == 0) chk("ar_beat_unexpected", 64'(cur_beat), 64'h0);
            else chk("ar_beat", 64'(cur_beat), 64'(exp_q[0]));
        end
        m_load = (|m_elig) && (!m_valid || ar_ready) && !reset;
        m_ack  = '0;
        if (m_load) begin
            for (int k = 0; k < N; k++) begin
                g = (m_ptr + k) % N;
                if (m_elig[g] && m_ack == '0) begin
                    m_ack[g] = 1'b1;
                    gi = g;
                end
            end
        end
        last_ack = ack;
        chk("ack", 64'(ack), 64'(m_ack));
        @(posedge clk);
        if (reset) begin
            exp_q.delete();
            m_valid = 1'b0;
            m_ptr   = 0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else begin
            if (m_valid && ar_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (m_load) begin
                exp_q.push_back({3'b000, 4'b0000, 1'b0, 2'b01, size[gi], len[gi], addr[gi], 4'(BASE + gi)});
                m_ptr = (gi + 1) % N;
            end
            m_valid = m_load || (m_valid && !ar_ready);
            for (int i = 0; i < N; i++) begin
                dec = r_valid && r_ready && r_last && (r_id == 4'(BASE + i));
                assert (!(dec && !m_ack[i] && m_cnt[i] == 0))
                    else $error("completion for requester %0d with nothing outstanding", i);
                if (m_ack[i] && !dec) m_cnt[i]++;
                else if (dec && !m_ack[i] && m_cnt[i] > 0) m_cnt[i]--;
            end
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (m_ack[i]) begin
                if (rereq[i]) new_req_fields(i);
                else req[i] = 1'b0;
            end
        end
    endtask

    // Let every pending request get acked and complete every outstanding read.
    task automatic drain();
        bit idle;
        rereq = '0;
        ar_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            idle = (req == '0) && !m_valid;
            for (int i = 0; i < N; i++) if (m_cnt[i] != 0) idle = 0;
            if (idle) break;
            idle_r();
            for (int i = N - 1; i >= 0; i--) begin
                if (m_cnt[i] > 0) begin
                    r_valid = 1'b1; r_ready = 1'b1; r_last = 1'b1; r_id = 4'(BASE + i);
                end
            end
            step();
        end
        idle_r();
        #1;
        chk("drain_idle", 64'({ar_valid, outst_full, req}), 64'h0);
    endtask

    logic [N-1:0] order [5];

    initial begin
        reset = 1'b1; rst2 = 1'b1;
        req = '0; rereq = '0; ar_ready = 1'b0; idle_r();
        for (int i = 0; i < N; i++) begin addr[i] = '0; len[i] = '0; size[i] = '0; m_cnt[i] = 0; end
        m_ptr = 0; m_valid = 1'b0; last_ack = '0;
        req2 = '0; addr2_v = '0;
        order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001; order[4] = 3'b010;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; rst2 = 1'b0;
        #1;
        chk("rst_ar_valid", 64'(ar_valid), 64'h0);
        chk("rst_ar_fields", 64'(cur_beat), 64'h0);
        chk("rst_ack", 64'(ack), 64'h0);
        chk("rst_full", 64'(outst_full), 64'h0);

        // Fixed priority, two requesters: LSU first, then IFU.
        @(negedge clk);
        req2 = 2'b11; addr2_v = {32'h2000_0040, 32'h1000_0080};
        #1 chk("t1_ack_lsu", 64'(ack2), 64'h2);
        @(negedge clk);
        req2 = 2'b01;
        #1;
        chk("t1_ack_ifu", 64'(ack2), 64'h1);
        chk("t1_valid", 64'(ar_valid2), 64'h1);
        chk("t1_id_lsu", 64'(ar_id2), 64'h3);
        chk("t1_addr_lsu", 64'(ar_addr2), 64'h2000_0040);
        chk("t1_burst", 64'({ar_burst2, ar_size2}), 64'({2'b01, 3'b010}));
        @(negedge clk);
        req2 = 2'b00;
        #1;
        chk("t1_id_ifu", 64'(ar_id2), 64'h2);
        chk("t1_addr_ifu", 64'(ar_addr2), 64'h1000_0080);
        chk("t1_no_ack", 64'(ack2), 64'h0);
        @(negedge clk);
        #1 chk("t1_drained", 64'(ar_valid2), 64'h0);
        @(negedge clk);

        // Round-robin order with all requesters held.
        for (int i = 0; i < N; i++) new_req_fields(i);
        req = 3'b111; rereq = 3'b111; ar_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t2_order", 64'(last_ack), 64'(order[k]));
        end
        drain();

        // AR held for 5 cycles while the slave stalls.
        for (int i = 0; i < N; i++) new_req_fields(i);
        req = 3'b111; ar_ready = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t3_no_ack", 64'(last_ack), 64'h0);
        end
        ar_ready = 1'b1;
        step();
        chk("t3_reload", 64'(last_ack != '0), 64'h1);
        drain();

        // Requester 0 fills its outstanding slots, then a completion frees one.
        new_req_fields(0);
        req = 3'b001; rereq = 3'b001; ar_ready = 1'b1;
        step(); step();
        rereq = '0;
        step();
        chk("t4_full", 64'(outst_full[0]), 64'h1);
        chk("t4_blocked", 64'(last_ack), 64'h0);
        r_valid = 1'b1; r_ready = 1'b1; r_last = 1'b1; r_id = 4'(BASE);
        step();
        chk("t4_still_blocked", 64'(last_ack), 64'h0);
        idle_r();
        step();
        chk("t4_reack", 64'(last_ack), 64'h1);
        drain();

        // Same-cycle issue and completion; non-last and foreign beats are ignored.
        new_req_fields(0); req = 3'b001;
        step();
        new_req_fields(0); req = 3'b001;
        r_valid = 1'b1; r_ready = 1'b1; r_last = 1'b1; r_id = 4'(BASE);
        step();
        chk("t5_same_cycle_ack", 64'(last_ack), 64'h1);
        r_last = 1'b0;
        step();
        r_last = 1'b1; r_id = 4'h7;
        step();
        r_id = 4'h3;
        step();
        idle_r();
        new_req_fields(0); req = 3'b001;
        step();
        step();
        chk("t5_full", 64'(outst_full[0]), 64'h1);
        drain();

        // Reset mid-operation drops the pending AR and restarts the pointer.
        for (int i = 0; i < N; i++) new_req_fields(i);
        req = 3'b111; ar_ready = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0; req = '0;
        #1;
        chk("t6_valid_cleared", 64'(ar_valid), 64'h0);
        chk("t6_full_cleared", 64'(outst_full), 64'h0);
        @(negedge clk);
        for (int i = 0; i < N; i++) new_req_fields(i);
        req = 3'b111; ar_ready = 1'b1;
        step();
        chk("t6_ptr_restart", 64'(last_ack), 64'h1);
        drain();

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    new_req_fields(i); req[i] = 1'b1;
                end else if (req[i] && $urandom_range(0, 7) == 0) begin
                    addr[i] = $urandom;
                end
            end
            ar_ready = ($urandom_range(0, 3) != 0);
            idle_r();
            if ($urandom_range(0, 1) == 0) begin
                int i;
                i = $urandom_range(0, N - 1);
                r_valid = 1'b1;
                r_ready = ($urandom_range(0, 3) != 0);
                r_last  = ($urandom_range(0, 2) != 0);
                if (m_cnt[i] > 0) r_id = 4'(BASE + i);
                else r_id = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(7, 15));
            end
            step();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
